// File: rtl/rand_window_stats_if.sv
// Result port of rand_window_stats: one window result plus valid/ready handshake.
// With RAND_STATS_SUM_EN defined the port also carries the window sum.
interface rand_window_stats_if #(
    parameter int WINDOW = 16
);
    localparam int CW = $clog2(WINDOW + 1);
`ifdef RAND_STATS_SUM_EN
    localparam int SW = 8 + $clog2(WINDOW);
`endif

    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] cnt2;
    logic [CW-1:0] cnt3;
    logic [CW-1:0] cnt5;
    logic [7:0]    min_val;
    logic [7:0]    max_val;
    logic          overrun;
`ifdef RAND_STATS_SUM_EN
    logic [SW-1:0] sum_val;
`endif

`ifdef RAND_STATS_SUM_EN
    modport master (
        output res_valid, cnt2, cnt3, cnt5, min_val, max_val, overrun, sum_val,
        input  res_ready
    );
    modport slave (
        input  res_valid, cnt2, cnt3, cnt5, min_val, max_val, overrun, sum_val,
        output res_ready
    );
`else
    modport master (
        output res_valid, cnt2, cnt3, cnt5, min_val, max_val, overrun,
        input  res_ready
    );
    modport slave (
        input  res_valid, cnt2, cnt3, cnt5, min_val, max_val, overrun,
        output res_ready
    );
`endif
endinterface

// File: rtl/rand_window_stats.sv
// Windowed statistics (flag hit counts, min, max) over WINDOW enabled random samples.
// Optional window sum output enabled by defining RAND_STATS_SUM_EN.
module rand_window_stats #(
    parameter int WINDOW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [7:0]            rand_num,
    input  logic [2:0]            flags,
    input  logic                  clr,
    rand_window_stats_if.master   res
);
    localparam int CW = $clog2(WINDOW + 1);
    localparam int IW = $clog2(WINDOW);
`ifdef RAND_STATS_SUM_EN
    localparam int SW = 8 + $clog2(WINDOW);
`endif

    typedef enum logic {EMPTY, FULL} state_t;

    state_t        state;
    logic [IW-1:0] acc_idx;
    logic [CW-1:0] acc_cnt2;
    logic [CW-1:0] acc_cnt3;
    logic [CW-1:0] acc_cnt5;
    logic [7:0]    acc_min;
    logic [7:0]    acc_max;
`ifdef RAND_STATS_SUM_EN
    logic [SW-1:0] acc_sum;
    logic [SW-1:0] nxt_sum;
`endif

    logic [CW-1:0] nxt_cnt2;
    logic [CW-1:0] nxt_cnt3;
    logic [CW-1:0] nxt_cnt5;
    logic [7:0]    nxt_min;
    logic [7:0]    nxt_max;
    logic          complete;
    logic          load;
    logic          drop;

    // Window totals including the current sample, so the last sample lands in the result
    always_comb begin
        nxt_cnt2 = acc_cnt2 + CW'(flags[2]);
        nxt_cnt3 = acc_cnt3 + CW'(flags[1]);
        nxt_cnt5 = acc_cnt5 + CW'(flags[0]);
        nxt_min  = (rand_num < acc_min) ? rand_num : acc_min;
        nxt_max  = (rand_num > acc_max) ? rand_num : acc_max;
`ifdef RAND_STATS_SUM_EN
        nxt_sum  = acc_sum + SW'(rand_num);
`endif
        complete = en && (acc_idx == IW'(WINDOW - 1));
        load     = complete && ((state == EMPTY) || res.res_ready);
        drop     = complete && (state == FULL) && !res.res_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_idx  <= '0;
            acc_cnt2 <= '0;
            acc_cnt3 <= '0;
            acc_cnt5 <= '0;
            acc_min  <= 8'hFF;
            acc_max  <= 8'h00;
`ifdef RAND_STATS_SUM_EN
            acc_sum  <= '0;
`endif
        end else if (clr || complete) begin
            // A finished window restarts immediately so no sample is lost
            acc_idx  <= '0;
            acc_cnt2 <= '0;
            acc_cnt3 <= '0;
            acc_cnt5 <= '0;
            acc_min  <= 8'hFF;
            acc_max  <= 8'h00;
`ifdef RAND_STATS_SUM_EN
            acc_sum  <= '0;
`endif
        end else if (en) begin
            acc_idx  <= acc_idx + 1'b1;
            acc_cnt2 <= nxt_cnt2;
            acc_cnt3 <= nxt_cnt3;
            acc_cnt5 <= nxt_cnt5;
            acc_min  <= nxt_min;
            acc_max  <= nxt_max;
`ifdef RAND_STATS_SUM_EN
            acc_sum  <= nxt_sum;
`endif
        end
    end

    // Result holding FSM; a result is only replaced when the port is empty or being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            res.res_valid <= 1'b0;
            res.overrun   <= 1'b0;
            res.cnt2      <= '0;
            res.cnt3      <= '0;
            res.cnt5      <= '0;
            res.min_val   <= '0;
            res.max_val   <= '0;
`ifdef RAND_STATS_SUM_EN
            res.sum_val   <= '0;
`endif
        end else if (clr) begin
            state         <= EMPTY;
            res.res_valid <= 1'b0;
            res.overrun   <= 1'b0;
            res.cnt2      <= '0;
            res.cnt3      <= '0;
            res.cnt5      <= '0;
            res.min_val   <= '0;
            res.max_val   <= '0;
`ifdef RAND_STATS_SUM_EN
            res.sum_val   <= '0;
`endif
        end else begin
            if (load) begin
                res.cnt2    <= nxt_cnt2;
                res.cnt3    <= nxt_cnt3;
                res.cnt5    <= nxt_cnt5;
                res.min_val <= nxt_min;
                res.max_val <= nxt_max;
`ifdef RAND_STATS_SUM_EN
                res.sum_val <= nxt_sum;
`endif
            end
            if (drop) begin
                res.overrun <= 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (complete) begin
                        state         <= FULL;
                        res.res_valid <= 1'b1;
                    end
                end
                FULL: begin
                    if (res.res_ready && !complete) begin
                        state         <= EMPTY;
                        res.res_valid <= 1'b0;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    res.res_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rand_window_stats.sv
// Directed vector bench for rand_window_stats with WINDOW=4 (CW=3).
module tb_rand_window_stats;
    localparam int WINDOW = 4;
    localparam int NV = 34;

    typedef struct {
        logic       en;
        logic [7:0] rn;
        logic [2:0] fl;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic       eov;
        logic [2:0] e2;
        logic [2:0] e3;
        logic [2:0] e5;
        logic [7:0] emin;
        logic [7:0] emax;
        logic [9:0] esum;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] rand_num;
    logic [2:0] flags;
    logic       clr;

    int   checks;
    int   errors;
    vec_t vecs[NV];
    int   nvec;

    rand_window_stats_if #(.WINDOW(WINDOW)) res_if ();

    rand_window_stats #(.WINDOW(WINDOW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rand_num (rand_num),
        .flags    (flags),
        .clr      (clr),
        .res      (res_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addVec(input int v_en, input int v_rn, input int v_fl, input int v_rdy,
                          input int v_clr, input int v_ev, input int v_ov, input int v_c2,
                          input int v_c3, input int v_c5, input int v_mn, input int v_mx,
                          input int v_sm);
        vec_t v;
        v.en   = v_en[0];
        v.rn   = v_rn[7:0];
        v.fl   = v_fl[2:0];
        v.rdy  = v_rdy[0];
        v.clr  = v_clr[0];
        v.ev   = v_ev[0];
        v.eov  = v_ov[0];
        v.e2   = v_c2[2:0];
        v.e3   = v_c3[2:0];
        v.e5   = v_c5[2:0];
        v.emin = v_mn[7:0];
        v.emax = v_mx[7:0];
        v.esum = v_sm[9:0];
        vecs[nvec] = v;
        nvec++;
    endtask

    task automatic applyStimulus(input vec_t v);
        en              = v.en;
        rand_num        = v.rn;
        flags           = v.fl;
        res_if.res_ready = v.rdy;
        clr             = v.clr;
    endtask

    task automatic checkAll(input string tag, input int ev, input int ov, input int c2,
                            input int c3, input int c5, input int mn, input int mx,
                            input int sm);
        checkOutput($sformatf("%s res_valid", tag), 32'(res_if.res_valid), 32'(ev));
        checkOutput($sformatf("%s overrun", tag), 32'(res_if.overrun), 32'(ov));
        checkOutput($sformatf("%s cnt2", tag), 32'(res_if.cnt2), 32'(c2));
        checkOutput($sformatf("%s cnt3", tag), 32'(res_if.cnt3), 32'(c3));
        checkOutput($sformatf("%s cnt5", tag), 32'(res_if.cnt5), 32'(c5));
        checkOutput($sformatf("%s min_val", tag), 32'(res_if.min_val), 32'(mn));
        checkOutput($sformatf("%s max_val", tag), 32'(res_if.max_val), 32'(mx));
`ifdef RAND_STATS_SUM_EN
        checkOutput($sformatf("%s sum_val", tag), 32'(res_if.sum_val), 32'(sm));
`else
        if (sm < 0) $display("[TB] unexpected negative sum %0d", sm);
`endif
    endtask

    task automatic sample(input logic [7:0] rn, input logic [2:0] fl, input logic rdy);
        en               = 1'b1;
        rand_num         = rn;
        flags            = fl;
        res_if.res_ready = rdy;
        clr              = 1'b0;
        tick();
        en = 1'b0;
    endtask

    initial begin
        logic [7:0] gs[4];
        logic [2:0] gf[4];
        logic [7:0] xs[4];
        checks = 0;
        errors = 0;
        nvec   = 0;

        // basic window, hold, transfer
        addVec(1, 'h97, 'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 'h1E, 'b111, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 'h5E, 'b100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        addVec(1, 'hBC, 'b100, 0, 0, 1, 0, 3, 1, 1, 'h1E, 'hBC, 'h1CF);
        addVec(0, 'h00, 'b000, 0, 0, 1, 0, 3, 1, 1, 'h1E, 'hBC, 'h1CF);
        addVec(0, 'h00, 'b000, 1, 0, 0, 0, 3, 1, 1, 'h1E, 'hBC, 'h1CF);
        // back-to-back windows A and B with ready held high
        addVec(1, 'h10, 'b100, 1, 0, 0, 0, 3, 1, 1, 'h1E, 'hBC, 'h1CF);
        addVec(1, 'h20, 'b100, 1, 0, 0, 0, 3, 1, 1, 'h1E, 'hBC, 'h1CF);
        addVec(1, 'h05, 'b001, 1, 0, 0, 0, 3, 1, 1, 'h1E, 'hBC, 'h1CF);
        addVec(1, 'h03, 'b010, 1, 0, 1, 0, 2, 1, 1, 'h03, 'h20, 'h038);
        addVec(1, 'h0F, 'b011, 1, 0, 0, 0, 2, 1, 1, 'h03, 'h20, 'h038);
        addVec(1, 'h40, 'b100, 1, 0, 0, 0, 2, 1, 1, 'h03, 'h20, 'h038);
        addVec(1, 'h41, 'b000, 1, 0, 0, 0, 2, 1, 1, 'h03, 'h20, 'h038);
        addVec(1, 'h06, 'b110, 1, 0, 1, 0, 2, 2, 1, 'h06, 'h41, 'h096);
        addVec(0, 'h00, 'b000, 1, 0, 0, 0, 2, 2, 1, 'h06, 'h41, 'h096);
        // window E waits, window F completes on the same edge E is taken
        addVec(1, 'h11, 'b000, 0, 0, 0, 0, 2, 2, 1, 'h06, 'h41, 'h096);
        addVec(1, 'h12, 'b110, 0, 0, 0, 0, 2, 2, 1, 'h06, 'h41, 'h096);
        addVec(1, 'h21, 'b010, 0, 0, 0, 0, 2, 2, 1, 'h06, 'h41, 'h096);
        addVec(1, 'h33, 'b010, 0, 0, 1, 0, 1, 3, 0, 'h11, 'h33, 'h077);
        addVec(1, 'h50, 'b101, 0, 0, 1, 0, 1, 3, 0, 'h11, 'h33, 'h077);
        addVec(1, 'h60, 'b110, 0, 0, 1, 0, 1, 3, 0, 'h11, 'h33, 'h077);
        addVec(1, 'h70, 'b100, 0, 0, 1, 0, 1, 3, 0, 'h11, 'h33, 'h077);
        addVec(1, 'h08, 'b100, 1, 0, 1, 0, 4, 1, 1, 'h08, 'h70, 'h128);
        addVec(0, 'h00, 'b000, 1, 0, 0, 0, 4, 1, 1, 'h08, 'h70, 'h128);
        // overrun: window C held, window D dropped
        addVec(1, 'h01, 'b000, 0, 0, 0, 0, 4, 1, 1, 'h08, 'h70, 'h128);
        addVec(1, 'h02, 'b100, 0, 0, 0, 0, 4, 1, 1, 'h08, 'h70, 'h128);
        addVec(1, 'h03, 'b010, 0, 0, 0, 0, 4, 1, 1, 'h08, 'h70, 'h128);
        addVec(1, 'h04, 'b100, 0, 0, 1, 0, 2, 1, 0, 'h01, 'h04, 'h00A);
        addVec(1, 'h0A, 'b101, 0, 0, 1, 0, 2, 1, 0, 'h01, 'h04, 'h00A);
        addVec(1, 'h0B, 'b000, 0, 0, 1, 0, 2, 1, 0, 'h01, 'h04, 'h00A);
        addVec(1, 'h0C, 'b110, 0, 0, 1, 0, 2, 1, 0, 'h01, 'h04, 'h00A);
        addVec(1, 'h0D, 'b000, 0, 0, 1, 1, 2, 1, 0, 'h01, 'h04, 'h00A);
        addVec(0, 'h00, 'b000, 1, 0, 0, 1, 2, 1, 0, 'h01, 'h04, 'h00A);
        // clr beats en and handshake in the same cycle
        addVec(1, 'hAA, 'b111, 1, 1, 0, 0, 0, 0, 0, 'h00, 'h00, 'h000);

        rst_n            = 1'b0;
        en               = 1'b0;
        rand_num         = '0;
        flags            = '0;
        clr              = 1'b0;
        res_if.res_ready = 1'b0;
        tick();
        tick();
        checkAll("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < nvec; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkAll($sformatf("vec%0d", i), int'(vecs[i].ev), int'(vecs[i].eov),
                     int'(vecs[i].e2), int'(vecs[i].e3), int'(vecs[i].e5),
                     int'(vecs[i].emin), int'(vecs[i].emax), int'(vecs[i].esum));
        end
        clr = 1'b0;
        res_if.res_ready = 1'b0;

        // gapped enable: same basic window, 3 idle cycles between samples
        gs[0] = 8'h97; gs[1] = 8'h1E; gs[2] = 8'h5E; gs[3] = 8'hBC;
        gf[0] = 3'b000; gf[1] = 3'b111; gf[2] = 3'b100; gf[3] = 3'b100;
        for (int s = 0; s < 4; s++) begin
            sample(gs[s], gf[s], 1'b0);
            if (s < 3) begin
                checkOutput($sformatf("gap s%0d res_valid", s), 32'(res_if.res_valid), 32'd0);
                for (int g = 0; g < 3; g++) begin
                    tick();
                    checkOutput($sformatf("gap s%0d idle%0d res_valid", s, g),
                                32'(res_if.res_valid), 32'd0);
                end
            end
        end
        checkAll("gap result", 1, 0, 3, 1, 1, 'h1E, 'hBC, 'h1CF);
        res_if.res_ready = 1'b1;
        tick();
        res_if.res_ready = 1'b0;
        checkOutput("gap drained res_valid", 32'(res_if.res_valid), 32'd0);

        // async reset between edges discards a partial window
        sample(8'h80, 3'b111, 1'b0);
        sample(8'h01, 3'b111, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkAll("async reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        xs[0] = 8'h00; xs[1] = 8'hFF; xs[2] = 8'hFF; xs[3] = 8'h00;
        for (int s = 0; s < 4; s++) begin
            sample(xs[s], 3'b111, 1'b0);
            if (s < 3)
                checkOutput($sformatf("post-reset s%0d res_valid", s), 32'(res_if.res_valid), 32'd0);
        end
        checkAll("extremes", 1, 0, 4, 4, 4, 'h00, 'hFF, 'h1FE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rand_window_stats.md
Name: rand_window_stats

Overview:
- Downstream consumer of the 8-bit LFSR random source and its 3-bit divisibility flags (bit2 = div-by-2, bit1 = div-by-3, bit0 = div-by-5).
- Accumulates statistics over a window of WINDOW enabled samples: per-flag hit counts plus min and max sample value.
- Presents each completed window's result on a valid/ready output port, so the random source can be characterised on-board or by a downstream display/UART stage.

Parameters:
- WINDOW, 16, samples per window; legal range 2..255.
- CW, derived localparam = ceil(log2(WINDOW+1)), width of the count outputs (5 for the default WINDOW).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sample strobe; rand_num and flags are captured on this cycle.
- rand_num  in  8  random sample value.
- flags  in  3  divisibility flags {div2, div3, div5}; sampled as presented, no alignment applied.
- clr  in  1  synchronous clear of accumulators, result, and overrun flag.
- res_valid  out  1  result registers hold an unconsumed window result.
- res_ready  in  1  consumer accepts the result.
- cnt2 / cnt3 / cnt5  out  CW each  per-flag hit counts for the window.
- min_val  out  8  minimum rand_num in the window.
- max_val  out  8  maximum rand_num in the window.
- overrun  out  1  sticky; a completed window was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): res_valid=0, overrun=0, all result outputs 0.
  - Accumulators: counts=0, acc_min=8'hFF, acc_max=8'h00, sample index=0.
- Reset mid-window discards the partial window. Reset while res_valid=1 drops the pending result.
- Accumulate on every cycle with en=1:
  - Each count increments when its flag bit is 1.
  - acc_min = min(acc_min, rand_num); acc_max = max(acc_max, rand_num); comparisons unsigned.
  - Sample index increments.
- Window completion: en=1 with index==WINDOW-1.
  - Final values, including this cycle's sample, are transferred to the result registers.
  - res_valid rises on the next edge, so latency is 1 clock from the last sample.
  - Accumulators reinit in the same edge (counts 0, min FF, max 00, index 0). The next window may start on the very next cycle; there are no dead cycles.
- Handshake:
  - A transfer occurs on any edge with res_valid && res_ready.
  - Result outputs are stable while res_valid=1 and res_ready=0.
  - res_valid falls after a transfer unless a new window completes on the same edge. In that case res_valid stays 1 with the new data, and this is not an overrun.
- Overrun: a window completes while res_valid=1 and res_ready=0.
  - The new result is dropped; the old result is retained.
  - overrun is set and held until clr or reset.
  - Accumulation continues into the next window.
- clr=1:
  - Same effect as reset on the next edge.
  - Has priority over en and the handshake in that cycle.
- State machine, 2 states:
  - EMPTY: res_valid=0. Moves to FULL on window completion.
  - FULL: res_valid=1.
    - Transfer without completion: FULL->EMPTY.
    - Transfer with completion: stays FULL with the reload.
    - Completion without transfer: stays FULL and sets overrun.
- Counts never overflow, since max = WINDOW < 2^CW.

Optional Feature:
- Macro: RAND_STATS_SUM_EN.
- Defined:
  - Adds output port sum_val, width 8+ceil(log2(WINDOW)): unsigned sum of rand_num over the window.
  - sum_val is accumulated, latched and handshaken exactly like the counts; reset and clr set it to 0.
- Undefined: port and accumulator absent; all other behaviour identical.

Test Plan:
- Basic window, WINDOW=4, res_ready=0: en=1 for 4 cycles with samples {0x97 flags 000}, {0x1E 111}, {0x5E 100}, {0xBC 100}.
  - One clock after the 4th sample: res_valid=1, cnt2=3, cnt3=1, cnt5=1, min_val=0x1E, max_val=0xBC.
  - With RAND_STATS_SUM_EN: sum_val=0x1CF.
- Gapped enable: same 4 samples with en low for 3 cycles between each -> identical result; res_valid rises only after the 4th enabled sample.
- Back-to-back with handshake: res_ready=1 held, 8 consecutive enabled samples -> res_valid high for exactly 1 cycle after sample 4 and 1 cycle after sample 8, each with the correct window data; overrun=0.
- Overrun: res_ready=0, 8 enabled samples -> first result retained unchanged, overrun=1.
  - res_ready=1 -> transfer, res_valid=0, overrun stays 1.
  - clr=1 -> overrun=0.
- Async reset mid-window: 2 samples, then rst_n pulsed low between clock edges.
  - Outputs clear immediately.
  - The next 4 samples alone form the window; the pre-reset samples are absent from counts and min/max.
- Extremes: window of samples 0x00, 0xFF, 0xFF, 0x00, all flags 111 -> min_val=0x00, max_val=0xFF, cnt2=cnt3=cnt5=4 (no overflow at CW=3).
